// File: rtl/serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_pkg
//   Shared definitions for the bit-serial ALU sequencers.
//   - state_t : controller state encoding (IDLE=0, RUN=1, DONE=2), kept fixed
//               so that future sequencers and checkers share one encoding.
//   - DEFAULT_WIDTH : default operand width of the serial adder.
//   - can_accept() : true in the states where a start request is sampled.
// -----------------------------------------------------------------------------
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // start is only looked at when no operation is in flight
    function automatic logic can_accept(input state_t s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// -----------------------------------------------------------------------------
// halfadder / full_adder
//   1-bit full adder built from two half adders plus an OR of their carries.
//   halfadder ports : a, b (in)  -> s, c (out)
//   full_adder ports: a, b, cin (in) -> s, cout (out)
// -----------------------------------------------------------------------------
module halfadder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    halfadder u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    halfadder u_ha1 (
        .a (s0),
        .b (cin),
        .s (s),
        .c (c1)
    );

    // the two half-adder carries can never both be 1
    assign cout = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial adder sequencer: one shared 1-bit full adder processes WIDTH bit
//   positions, LSB first, one bit per clock. Low-area companion to the
//   combinational ALU add path.
//
// Parameters
//   WIDTH  operand/result width (>= 2); CNT_W = $clog2(WIDTH) is derived.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start          request, sampled only in IDLE or DONE
//   a, b           operands, captured when start is accepted
//   sub            1 = A-B (honoured only when SERIAL_ADD_SUB_EN is defined)
//   busy           high while the bit loop runs (WIDTH cycles)
//   done           one-cycle pulse; result/cout/overflow valid from here
//   result         sum/difference, held until the next accepted start's
//                  first RUN edge
//   cout           carry out of the MSB (subtract: 1 = no borrow, A>=B)
//   overflow       signed overflow = carry into MSB ^ carry out of MSB
//   dbg_state      current controller state, for debug/checkers
//
// Handshake: start is a level request with no ready signal. It is accepted on
// any rising edge where the controller is in IDLE or DONE; while busy it is
// ignored (not queued). done is a single-cycle completion strobe and needs no
// acknowledge; holding start high in DONE launches the next operation
// back-to-back.
//
// Configuration
//   SERIAL_ADD_SUB_EN defined : sub honoured, subtract = A + ~B + 1.
//   undefined (default)       : sub ignored, always add with carry-in 0.
// -----------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output state_t           dbg_state
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic             accept;
    logic             step;
    logic             last;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] b_in;
    logic             sub_eff;
    logic             fa_s;
    logic             fa_c;

`ifdef SERIAL_ADD_SUB_EN
    // two's complement subtract: invert B and inject carry-in of 1
    assign sub_eff = sub;
    assign b_in    = sub ? ~b : b;
`else
    logic sub_unused;
    assign sub_unused = sub;
    assign sub_eff    = 1'b0;
    assign b_in       = b;
`endif

    full_adder u_fa (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        step     = 1'b0;
        last     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt == CNT_LAST) begin
                    last     = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = ST_RUN;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        // accept is only ever raised in IDLE/DONE; keep the two views tied
        accept = accept & can_accept(state);
    end

    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign dbg_state = state;

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa       <= '0;
            sb       <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            // result is left alone here so it stays readable during DONE
            sa    <= a;
            sb    <= b_in;
            carry <= sub_eff;
            cnt   <= '0;
        end else if (step) begin
            // each sum bit enters at the MSB; after WIDTH steps bit 0 is LSB
            result <= {fa_s, result[WIDTH-1:1]};
            sa     <= {1'b0, sa[WIDTH-1:1]};
            sb     <= {1'b0, sb[WIDTH-1:1]};
            carry  <= fa_c;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                // at the MSB step, carry holds the carry into the MSB
                cout     <= fa_c;
                overflow <= fa_c ^ carry;
            end
        end
    end

endmodule
